// File: rtl/mult16_seq.sv
// Iterative unsigned shift-and-add multiplier with a start/done handshake.
// Takes WIDTH cycles from the accepting edge to done. A start while busy is ignored.
module mult16_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mcand;
  // Upper accumulator keeps only its low WIDTH bits; the top bit is always 0 after the shift.
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_s;
  logic             add_c;
  logic [WIDTH:0]   sum17;

  // The upstream adder has no carry-out, so the carry is recovered from operand and sum MSBs.
  always_comb begin
    add_a = acc_hi;
    add_b = acc_lo[0] ? mcand : '0;
    add_s = add_a + add_b;
    add_c = (add_a[WIDTH-1] & add_b[WIDTH-1]) |
            ((add_a[WIDTH-1] | add_b[WIDTH-1]) & ~add_s[WIDTH-1]);
    sum17 = {add_c, add_s};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      count  <= '0;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      P      <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            mcand  <= A;
            acc_lo <= B;
            acc_hi <= '0;
            count  <= '0;
            P      <= '0;
            state  <= S_RUN;
          end else begin
            state  <= S_IDLE;
          end
        end
        S_RUN: begin
          acc_hi <= sum17[WIDTH:1];
          acc_lo <= {sum17[0], acc_lo[WIDTH-1:1]};
          count  <= count + 1'b1;
          if (count == LAST) begin
            state <= S_DONE;
            P     <= {sum17, acc_lo[WIDTH-1:1]};
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_mult16_seq.sv
// Randomized and directed bench for mult16_seq; reference product is plain a*b.
module tb_mult16_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        busy;
  logic        done;
  logic [31:0] P;

  int n_cmp = 0;
  int n_fail = 0;

  mult16_seq #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .P     (P)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    return 32'(a) * 32'(b);
  endfunction

  // Leaves the bench at the first falling edge after the accepting edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts falling edges until done is seen (bounded), tallying busy cycles and P leaks.
  task automatic wait_done(output int cycles, output int busy_cnt, output bit leak);
    cycles = 0;
    busy_cnt = 0;
    leak = 1'b0;
    while (!done && cycles < 40) begin
      if (busy) busy_cnt++;
      if (P !== 32'd0) leak = 1'b1;
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, P} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%0b done=%0b P=%h, want all 0", busy, done, P);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int cyc, bcnt;
    bit leak;
    start_op(16'h0003, 16'h0005);
    wait_done(cyc, bcnt, leak);
    n_cmp++;
    if (cyc !== 16) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d cycles, want 16", cyc);
    end
    n_cmp++;
    if (bcnt !== 16) begin
      n_fail++;
      $display("FAIL basic_busy_len: busy %0d cycles, want 16", bcnt);
    end
    n_cmp++;
    if (leak !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_p_during_run: P nonzero while busy, want 0");
    end
    n_cmp++;
    if (P !== 32'h0000000F || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_cycle: P=%h busy=%0b, want 0000000f busy=0", P, busy);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || P !== 32'h0000000F) begin
        n_fail++;
        $display("FAIL basic_hold%0d: done=%0b busy=%0b P=%h, want 0 0 0000000f", i, done, busy, P);
      end
    end
  endtask

  task automatic test_corners();
    logic [15:0] ta [4] = '{16'hFFFF, 16'h8000, 16'h1234, 16'h0000};
    logic [15:0] tb [4] = '{16'hFFFF, 16'h0002, 16'h0000, 16'hABCD};
    int cyc, bcnt;
    bit leak;
    for (int i = 0; i < 4; i++) begin
      start_op(ta[i], tb[i]);
      wait_done(cyc, bcnt, leak);
      n_cmp++;
      if (cyc !== 16 || bcnt !== 16 || leak) begin
        n_fail++;
        $display("FAIL corner%0d_timing: cycles=%0d busy=%0d leak=%0b, want 16 16 0", i, cyc, bcnt, leak);
      end
      n_cmp++;
      if (P !== ref_mul(ta[i], tb[i])) begin
        n_fail++;
        $display("FAIL corner%0d_product: %h*%h got %h, want %h", i, ta[i], tb[i], P, ref_mul(ta[i], tb[i]));
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    int cyc, bcnt;
    bit leak;
    for (int i = 0; i < 24; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      start_op(a, b);
      wait_done(cyc, bcnt, leak);
      n_cmp++;
      if (cyc !== 16 || P !== ref_mul(a, b)) begin
        n_fail++;
        $display("FAIL random%0d: %h*%h got P=%h after %0d cycles, want %h after 16", i, a, b, P, cyc, ref_mul(a, b));
      end
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic test_start_ignored();
    int cyc, bcnt;
    bit leak;
    start_op(16'd7, 16'd9);
    repeat (4) @(negedge clk);
    A = 16'hFFFF;
    B = 16'hFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = 16'h5A5A;
    B = 16'hA5A5;
    wait_done(cyc, bcnt, leak);
    n_cmp++;
    if (cyc !== 11) begin
      n_fail++;
      $display("FAIL ignore_latency: done after %0d more cycles, want 11", cyc);
    end
    n_cmp++;
    if (P !== 32'h0000003F) begin
      n_fail++;
      $display("FAIL ignore_product: got %h, want 0000003f", P);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, bcnt;
    bit leak, seen;
    start_op(16'h00FF, 16'h0101);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, P} !== 34'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: busy=%0b done=%0b P=%h, want all 0", busy, done, P);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_no_done: busy/done seen after abort, want none");
    end
    start_op(16'd2, 16'd3);
    wait_done(cyc, bcnt, leak);
    n_cmp++;
    if (cyc !== 16 || P !== 32'd6) begin
      n_fail++;
      $display("FAIL midreset_fresh: P=%h after %0d cycles, want 00000006 after 16", P, cyc);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bcnt;
    bit leak;
    start_op(16'd2, 16'd3);
    wait_done(cyc, bcnt, leak);
    n_cmp++;
    if (done !== 1'b1 || P !== 32'd6) begin
      n_fail++;
      $display("FAIL b2b_first: done=%0b P=%h, want 1 00000006", done, P);
    end
    A = 16'h0100;
    B = 16'h0100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b1 || P !== 32'd0) begin
      n_fail++;
      $display("FAIL b2b_accept: done=%0b busy=%0b P=%h, want 0 1 00000000", done, busy, P);
    end
    wait_done(cyc, bcnt, leak);
    n_cmp++;
    if (cyc !== 16 || leak || P !== 32'h00010000) begin
      n_fail++;
      $display("FAIL b2b_second: P=%h cycles=%0d leak=%0b, want 00010000 16 0", P, cyc, leak);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
